// File: rtl/fix_sched_pkg.sv
// Shared types and constants for the FIX outbound message scheduler.
// Used by fix_rr_arbiter and fix_tx_scheduler.
package fix_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SEQ,
        ST_BUSY
    } sched_state_t;

    // Internal 4-bit encodings of the session and application message types
    localparam logic [3:0] MSG_HEARTBEAT = 4'h0;
    localparam logic [3:0] MSG_TESTREQ   = 4'h1;
    localparam logic [3:0] MSG_RESEND    = 4'h2;
    localparam logic [3:0] MSG_REJECT    = 4'h3;
    localparam logic [3:0] MSG_LOGOUT    = 4'h5;
    localparam logic [3:0] MSG_LOGON     = 4'hA;

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fix_rr_arbiter.sv
// Combinational rotating-priority arbiter; searches upward from ptr+1 with wrap.
// With FIX_SCHED_PRIORITY_EN defined, requester 0 always wins and is skipped by the rotation.
module fix_rr_arbiter
    import fix_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
`ifdef FIX_SCHED_PRIORITY_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
`ifdef FIX_SCHED_PRIORITY_EN
            if (!found && idx != '0 && req[idx]) begin
`else
            if (!found && req[idx]) begin
`endif
                grant[idx] = 1'b1;
                winner     = idx;
                found      = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fix_tx_scheduler.sv
// Grants one outbound message job at a time, starts creation once the sequence
// number is ready and holds type/host until done or watchdog expiry.
// Optional build macro: FIX_SCHED_PRIORITY_EN (requester 0 pre-empts the rotation).
module fix_tx_scheduler
    import fix_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int HOST_W  = 4,
    parameter int TYPE_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*TYPE_W-1:0] req_type_i,
    input  logic [NUM_REQ*HOST_W-1:0] req_host_i,
    input  logic                      seq_ready_i,
    input  logic                      done_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      start_o,
    output logic [TYPE_W-1:0]         msg_type_o,
    output logic [HOST_W-1:0]         host_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

    sched_state_t       state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] pick;
    logic               any_req;
    logic [WD_W-1:0]    wd;

    fix_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req_i),
        .ptr    (ptr),
        .grant  (pick),
        .winner (winner),
        .valid  (any_req)
    );

    // Pulses default low every cycle; reset starts ptr at the last requester so 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            wd         <= '0;
            grant_o    <= '0;
            start_o    <= 1'b0;
            msg_type_o <= '0;
            host_o     <= '0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            grant_o   <= '0;
            start_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_o    <= pick;
                        msg_type_o <= req_type_i[int'(winner)*TYPE_W +: TYPE_W];
                        host_o     <= req_host_i[int'(winner)*HOST_W +: HOST_W];
                        busy_o     <= 1'b1;
`ifdef FIX_SCHED_PRIORITY_EN
                        if (winner != '0) begin
                            ptr <= winner;
                        end
`else
                        ptr <= winner;
`endif
                        state <= ST_WAIT_SEQ;
                    end
                end
                ST_WAIT_SEQ: begin
                    if (seq_ready_i) begin
                        start_o <= 1'b1;
                        wd      <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // done takes precedence over a simultaneous watchdog expiry
                    if (done_i) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (wd == WD_LAST) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wd != WD_MAX) begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_tx_scheduler.sv
// Self-checking bench for fix_tx_scheduler: directed scenarios then random traffic,
// every output compared each cycle against a job-level reference model.
module tb_fix_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int HOST_W  = 4;
    localparam int TYPE_W  = 4;
    localparam int TIMEOUT = 8;
`ifdef FIX_SCHED_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_JOB  = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        reqV;
    logic [NUM_REQ*TYPE_W-1:0] reqType;
    logic [NUM_REQ*HOST_W-1:0] reqHost;
    logic                      seqReady;
    logic                      done;
    logic [NUM_REQ-1:0]        grant;
    logic                      start;
    logic [TYPE_W-1:0]         msgType;
    logic [HOST_W-1:0]         host;
    logic                      busy;
    logic                      timeout;

    fix_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .HOST_W  (HOST_W),
        .TYPE_W  (TYPE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (reqV),
        .req_type_i  (reqType),
        .req_host_i  (reqHost),
        .seq_ready_i (seqReady),
        .done_i      (done),
        .grant_o     (grant),
        .start_o     (start),
        .msg_type_o  (msgType),
        .host_o      (host),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    logic [NUM_REQ-1:0] pending;
    logic [TYPE_W-1:0]  pType [NUM_REQ];
    logic [HOST_W-1:0]  pHost [NUM_REQ];

    int                 mPhase;
    int                 mLast;
    int                 mAge;
    logic [NUM_REQ-1:0] eGrant;
    logic               eStart;
    logic               eTimeout;
    logic               eBusy;
    logic [TYPE_W-1:0]  eType;
    logic [HOST_W-1:0]  eHost;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Next requester after the last winner, wrapping; requester 0 pre-empts in priority builds
    function automatic int rrPick(input logic [NUM_REQ-1:0] r, input int last);
        int k;
        if (PRIO && r[0]) return 0;
        for (int s = 1; s <= NUM_REQ; s++) begin
            k = (last + s) % NUM_REQ;
            if (PRIO && k == 0) continue;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int w;
        eGrant   = '0;
        eStart   = 1'b0;
        eTimeout = 1'b0;
        if (rst) begin
            mPhase = PH_IDLE;
            mLast  = NUM_REQ - 1;
            eBusy  = 1'b0;
            eType  = '0;
            eHost  = '0;
        end else if (mPhase == PH_IDLE) begin
            w = rrPick(reqV, mLast);
            if (w >= 0) begin
                eGrant[w] = 1'b1;
                eType     = reqType[w*TYPE_W +: TYPE_W];
                eHost     = reqHost[w*HOST_W +: HOST_W];
                eBusy     = 1'b1;
                if (!PRIO || w != 0) mLast = w;
                mPhase = PH_WAIT;
            end
        end else if (mPhase == PH_WAIT) begin
            if (seqReady) begin
                eStart = 1'b1;
                mAge   = 0;
                mPhase = PH_JOB;
            end
        end else begin
            // mAge = number of cycles the job has spent after its start cycle began
            mAge++;
            if (done) begin
                eBusy  = 1'b0;
                mPhase = PH_IDLE;
            end else if (mAge == TIMEOUT) begin
                eTimeout = 1'b1;
                eBusy    = 1'b0;
                mPhase   = PH_IDLE;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge
    task automatic applyStimulus(input logic [NUM_REQ-1:0] raise, input logic seq,
                                 input logic dn, input logic rs);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (raise[k] && !pending[k]) begin
                pending[k] = 1'b1;
                pType[k]   = TYPE_W'($urandom);
                pHost[k]   = HOST_W'($urandom);
            end
            reqType[k*TYPE_W +: TYPE_W] = pType[k];
            reqHost[k*HOST_W +: HOST_W] = pHost[k];
        end
        reqV     = pending;
        seqReady = seq;
        done     = dn;
        rst      = rs;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("grant", 32'(grant), 32'(eGrant));
        checkOutput("start", 32'(start), 32'(eStart));
        checkOutput("timeout", 32'(timeout), 32'(eTimeout));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("msg_type", 32'(msgType), 32'(eType));
        checkOutput("host", 32'(host), 32'(eHost));
        pending = pending & ~eGrant;
    endtask

    initial begin
        pending = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pType[k] = '0;
            pHost[k] = '0;
        end
        mPhase = PH_IDLE;
        mLast  = NUM_REQ - 1;
        mAge   = 0;
        eBusy  = 1'b0;
        eType  = '0;
        eHost  = '0;

        // Reset state
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 1'b1, 1'b1, 1'b0);

        // Single request from requester 1, seq ready tied high, job of 5 cycles
        pending[1] = 1'b1;
        pType[1]   = 4'h1;
        pHost[1]   = 4'h3;
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        checkOutput("plan_grant", 32'(grant), 32'h2);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        checkOutput("plan_start", 32'(start), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);
        checkOutput("plan_type_hold", 32'(msgType), 32'h1);
        checkOutput("plan_host_hold", 32'(host), 32'h3);
        applyStimulus('0, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // All four requesting continuously, done five cycles after each start
        for (int i = 0; i < 40; i++) applyStimulus('1, 1'b1, (i % 7) == 6, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus('0, 1'b1, 1'b1, 1'b0);

        // Sequence number stalls for 10 cycles; done during the stall is ignored
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus('0, 1'b0, (i % 3) == 0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b1, 1'b0);

        // Watchdog expiry with a request waiting behind it
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // done lands exactly on the expiry cycle
        for (int i = 0; i < 4; i++) applyStimulus('0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a job, then contention
        applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b1);
        applyStimulus('1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus('0, 1'b1, 1'b1, 1'b0);

        // Random traffic with periodic sequence stalls and rare resets
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_REQ-1:0] raise;
            logic               seq;
            for (int k = 0; k < NUM_REQ; k++) raise[k] = ($urandom_range(0, 5) == 0);
            seq = (c % 150 >= 100 && c % 150 < 114) ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(raise, seq, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fix_tx_scheduler.md
# fix_tx_scheduler

Arbitrates the single outbound message-creation pipeline among NUM_REQ requesters: session controller, heartbeat timer, resend logic and application. Each request carries a message type and a destination host. The scheduler grants one request at a time, waits for the sequence generator to be ready, and fires a one-cycle start into message creation. It then holds the selected type and host stable until the creation FSM reports end of message, or until a watchdog expires.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- HOST_W, 4, host address width
- TYPE_W, 4, message type width
- TIMEOUT, 255, watchdog limit in cycles while BUSY (1..2^16-1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_i  in  NUM_REQ  per-requester request level, held until granted
- req_type_i  in  NUM_REQ*TYPE_W  packed message type, requester k at bits [k*TYPE_W +: TYPE_W]
- req_host_i  in  NUM_REQ*HOST_W  packed destination host, same packing
- seq_ready_i  in  1  outgoing sequence number valid
- done_i  in  1  end-of-message pulse from creation FSM
- grant_o  out  NUM_REQ  one-hot, one-cycle grant pulse
- start_o  out  1  one-cycle start to message creation
- msg_type_o  out  TYPE_W  latched type of current job
- host_o  out  HOST_W  latched host of current job
- busy_o  out  1  high from grant until job retires
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, WAIT_SEQ, BUSY.
- IDLE, any req_i high:
  - pick a winner by round-robin, searching upward from ptr+1 with wrap
  - register grant_o (one-hot winner), msg_type_o, host_o; set busy_o
  - ptr <= winner; go to WAIT_SEQ
- IDLE, no request: nothing happens; all pulses low.
- WAIT_SEQ:
  - seq_ready_i high -> start_o pulse, clear watchdog, go to BUSY
  - done_i is ignored in this state
- BUSY:
  - watchdog counts up every cycle
  - done_i high -> IDLE, busy_o low the next cycle
  - count reaches TIMEOUT-1 with done_i low -> timeout_o pulse, go to IDLE
  - done_i and expiry in the same cycle -> done wins, no timeout_o
- req_i is sampled only in IDLE. Requester k must drop req_i after seeing grant_o[k]. A req_i still high when the scheduler returns to IDLE is treated as a new request.
- msg_type_o and host_o change only at grant; they hold their value after the job retires.
- Watchdog width is clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, ptr NUM_REQ-1 (requester 0 wins first)
  - all outputs 0, including msg_type_o and host_o
- rst asserted in any state returns to IDLE the next cycle. No start_o or timeout_o is emitted from that cycle on.
- req_i high at edge N (IDLE) -> grant_o and busy_o high in cycle N+1.
- start_o comes at the earliest in cycle N+2, when seq_ready_i is high at edge N+1. It otherwise waits indefinitely.
- done_i at edge M (BUSY) -> IDLE in M+1, next grant at the earliest in M+2. The minimum gap between start_o pulses is 3 cycles plus the job length.

## Configuration
- FIX_SCHED_PRIORITY_EN defined:
  - requester 0 (session controller: logout, reject, heartbeat) wins whenever it requests
  - other requesters rotate round-robin among themselves; ptr is not updated on a requester-0 grant
- Not defined: pure round-robin over all NUM_REQ requesters.

## Structure
- Package fix_sched_pkg:
  - state enum
  - message type constants MSG_LOGON, MSG_HEARTBEAT, MSG_TESTREQ, MSG_LOGOUT, MSG_RESEND, MSG_REJECT
  - function for the watchdog width
- One sub-module, fix_rr_arbiter: combinational rotating-priority pick with inputs req and ptr, outputs one-hot grant and winner index. It also implements the priority override under FIX_SCHED_PRIORITY_EN.

## Test plan
- Single request, seq_ready_i tied high: req_i=4'b0010, type 4'h1, host 4'h3 at edge 0 -> grant_o=0010 cycle 1; start_o cycle 2; msg_type_o=1 and host_o=3 hold until done_i.
- All four requesting continuously, done_i 5 cycles after each start: grants 0,1,2,3,0 in that order. With FIX_SCHED_PRIORITY_EN: 0,0,0… while req_i[0] stays high.
- seq_ready_i low for 10 cycles after grant: no start_o, busy_o stays high; start_o exactly one cycle after seq_ready_i rises.
- TIMEOUT=8 with no done_i: timeout_o pulses exactly once, 8 cycles after start_o; IDLE next cycle; a pending request is granted.
- done_i in WAIT_SEQ is ignored. done_i coinciding with expiry gives no timeout_o. rst in BUSY: all outputs 0 next cycle and the next grant goes to requester 0.
